// File: rtl/load_tag_buffer_pkg.sv
// Shared types and helpers for the load tag buffer and its data aligner.
package load_buf_pkg;

  localparam int unsigned MAX_ENTRIES = 8;
  localparam int unsigned TRANS_ID_W  = 3;

  typedef enum logic [1:0] {
    LD_B = 2'd0,
    LD_H = 2'd1,
    LD_W = 2'd2
  } ld_size_e;

  typedef struct packed {
    logic                  valid;
    logic                  killed;
    logic [TRANS_ID_W-1:0] trans_id;
    logic [1:0]            offset;
    ld_size_e              size;
    logic                  is_signed;
  } ld_slot_t;

  // Priority encoder: index of the lowest set bit of free_mask (0 if none set).
  function automatic int unsigned lowest_free(input logic [MAX_ENTRIES-1:0] free_mask);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = MAX_ENTRIES; i > 0; i--) begin
      if (free_mask[i-1]) idx = i - 1;
    end
    return idx;
  endfunction

endpackage

// File: rtl/load_tag_buffer_align.sv
// Combinational byte/half/word extraction and sign/zero extension of a raw cache word.
module load_data_align
  import load_buf_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] data_i,
  input  logic [1:0]      offset_i,
  input  ld_size_e        size_i,
  input  logic            signed_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Select the addressed field, then fill the upper bits with the sign or zero.
  always_comb begin
    byte_val = data_i[{offset_i, 3'b000} +: 8];
    half_val = data_i[{offset_i[1], 4'b0000} +: 16];
    data_o   = '0;
    case (size_i)
      LD_B: begin
        data_o      = {XLEN{signed_i & byte_val[7]}};
        data_o[7:0] = byte_val;
      end
      LD_H: begin
        data_o       = {XLEN{signed_i & half_val[15]}};
        data_o[15:0] = half_val;
      end
      default: begin
        data_o       = {XLEN{signed_i & data_i[31]}};
        data_o[31:0] = data_i[31:0];
      end
    endcase
  end

endmodule

// File: rtl/load_tag_buffer.sv
// Outstanding-load tracker between the load unit and the write-through data cache.
module load_tag_buffer
  import load_buf_pkg::*;
#(
  parameter  int unsigned NrEntries   = 2,
  parameter  int unsigned TransIdBits = TRANS_ID_W,
  parameter  int unsigned XLEN        = 32,
  localparam int unsigned IdxBits     = (NrEntries > 1) ? $clog2(NrEntries) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   alloc_valid_i,
  output logic                   alloc_ready_o,
  input  logic [TransIdBits-1:0] alloc_trans_id_i,
  input  logic [1:0]             alloc_offset_i,
  input  logic [1:0]             alloc_size_i,
  input  logic                   alloc_signed_i,
  output logic [IdxBits-1:0]     alloc_idx_o,
  input  logic                   resp_valid_i,
  input  logic [IdxBits-1:0]     resp_idx_i,
  input  logic [XLEN-1:0]        resp_data_i,
  output logic                   wb_valid_o,
  output logic [TransIdBits-1:0] wb_trans_id_o,
  output logic [XLEN-1:0]        wb_data_o,
  output logic                   empty_o,
  output logic [IdxBits:0]       count_o
);

  ld_slot_t slots_q [NrEntries];
  ld_slot_t slots_d [NrEntries];

  logic                   wb_valid_q, wb_valid_d;
  logic [TransIdBits-1:0] wb_trans_id_q, wb_trans_id_d;
  logic [XLEN-1:0]        wb_data_q, wb_data_d;

  logic [MAX_ENTRIES-1:0] free_mask;
  logic                   alloc_fire;
  ld_slot_t               resp_slot;
  logic                   resp_hit;
  logic [XLEN-1:0]        aligned_data;
  logic [IdxBits:0]       valid_count;

  // Allocator: lowest free slot, looked up from registered state only.
  always_comb begin
    free_mask = '0;
    for (int unsigned i = 0; i < NrEntries; i++) begin
      free_mask[i] = ~slots_q[i].valid;
    end
    alloc_ready_o = (|free_mask) & ~flush_i;
    alloc_idx_o   = IdxBits'(lowest_free(free_mask));
    alloc_fire    = alloc_valid_i & alloc_ready_o;
  end

  // Response lookup: fetch the addressed slot; responses to idle slots are ignored.
  always_comb begin
    resp_slot = '0;
    for (int unsigned i = 0; i < NrEntries; i++) begin
      if (resp_idx_i == IdxBits'(i)) resp_slot = slots_q[i];
    end
    resp_hit = resp_valid_i & resp_slot.valid;
  end

  load_data_align #(
    .XLEN (XLEN)
  ) u_align (
    .data_i   (resp_data_i),
    .offset_i (resp_slot.offset),
    .size_i   (resp_slot.size),
    .signed_i (resp_slot.is_signed),
    .data_o   (aligned_data)
  );

  // Slot array next state: kill on flush, free on response, fill on allocation.
  always_comb begin
    for (int unsigned i = 0; i < NrEntries; i++) begin
      slots_d[i] = slots_q[i];
      if (flush_i && slots_q[i].valid) slots_d[i].killed = 1'b1;
      if (resp_hit && (resp_idx_i == IdxBits'(i))) slots_d[i] = '0;
      if (alloc_fire && (alloc_idx_o == IdxBits'(i))) begin
        slots_d[i].valid     = 1'b1;
        slots_d[i].killed    = 1'b0;
        slots_d[i].trans_id  = alloc_trans_id_i;
        slots_d[i].offset    = alloc_offset_i;
        slots_d[i].size      = ld_size_e'(alloc_size_i);
        slots_d[i].is_signed = alloc_signed_i;
      end
    end
  end

  // Write-back next state: only live responses outside a flush reach the scoreboard.
  always_comb begin
    wb_valid_d    = resp_hit & ~resp_slot.killed & ~flush_i;
    wb_trans_id_d = wb_trans_id_q;
    wb_data_d     = wb_data_q;
    if (wb_valid_d) begin
      wb_trans_id_d = resp_slot.trans_id;
      wb_data_d     = aligned_data;
    end
  end

  // Occupancy from registered valid bits, killed slots included.
  always_comb begin
    valid_count = '0;
    for (int unsigned i = 0; i < NrEntries; i++) begin
      valid_count = valid_count + (IdxBits + 1)'(slots_q[i].valid);
    end
    count_o = valid_count;
    empty_o = (valid_count == '0);
  end

  // State registers; reset drops every outstanding load.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NrEntries; i++) begin
        slots_q[i] <= '0;
      end
      wb_valid_q    <= 1'b0;
      wb_trans_id_q <= '0;
      wb_data_q     <= '0;
    end else begin
      for (int unsigned i = 0; i < NrEntries; i++) begin
        slots_q[i] <= slots_d[i];
      end
      wb_valid_q    <= wb_valid_d;
      wb_trans_id_q <= wb_trans_id_d;
      wb_data_q     <= wb_data_d;
    end
  end

  // Output drive from the write-back register.
  always_comb begin
    wb_valid_o    = wb_valid_q;
    wb_trans_id_o = wb_trans_id_q;
    wb_data_o     = wb_data_q;
  end

  // Protocol monitors: illegal requests are dropped by the logic above and only reported here.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(resp_valid_i && !resp_slot.valid))
        else $warning("load_tag_buffer: response to idle slot %0d ignored", resp_idx_i);
      assert (!(alloc_valid_i && !alloc_ready_o))
        else $warning("load_tag_buffer: allocation while not ready ignored");
    end
  end

endmodule

// File: tb/tb_load_tag_buffer.sv
// Directed and randomized check of load_tag_buffer against a slot-table reference model.
module tb_load_tag_buffer;

  localparam int NE = 2;
  localparam int IB = 1;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          flush_i;
  logic          alloc_valid_i;
  logic          alloc_ready_o;
  logic [2:0]    alloc_trans_id_i;
  logic [1:0]    alloc_offset_i;
  logic [1:0]    alloc_size_i;
  logic          alloc_signed_i;
  logic [IB-1:0] alloc_idx_o;
  logic          resp_valid_i;
  logic [IB-1:0] resp_idx_i;
  logic [31:0]   resp_data_i;
  logic          wb_valid_o;
  logic [2:0]    wb_trans_id_o;
  logic [31:0]   wb_data_o;
  logic          empty_o;
  logic [IB:0]   count_o;

  load_tag_buffer #(
    .NrEntries   (NE),
    .TransIdBits (3),
    .XLEN        (32)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .flush_i          (flush_i),
    .alloc_valid_i    (alloc_valid_i),
    .alloc_ready_o    (alloc_ready_o),
    .alloc_trans_id_i (alloc_trans_id_i),
    .alloc_offset_i   (alloc_offset_i),
    .alloc_size_i     (alloc_size_i),
    .alloc_signed_i   (alloc_signed_i),
    .alloc_idx_o      (alloc_idx_o),
    .resp_valid_i     (resp_valid_i),
    .resp_idx_i       (resp_idx_i),
    .resp_data_i      (resp_data_i),
    .wb_valid_o       (wb_valid_o),
    .wb_trans_id_o    (wb_trans_id_o),
    .wb_data_o        (wb_data_o),
    .empty_o          (empty_o),
    .count_o          (count_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one record per outstanding load plus the expected write-back.
  bit          m_valid  [NE];
  bit          m_killed [NE];
  int          m_id     [NE];
  int          m_off    [NE];
  int          m_size   [NE];
  bit          m_sgn    [NE];
  bit          e_wbv;
  int          e_wbid;
  logic [31:0] e_wbdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Field extraction by arithmetic: shift right by whole bytes, reduce modulo field range, wrap negative.
  function automatic logic [31:0] ref_extract(input logic [31:0] d, input int off, input int size, input bit sgn);
    int nbytes;
    int sh;
    longint unsigned v;
    longint unsigned lim;
    nbytes = (size == 0) ? 1 : (size == 1) ? 2 : 4;
    sh     = (size == 2) ? 0 : off;
    v      = {32'd0, d} >> (8 * sh);
    lim    = 64'd1 << (8 * nbytes);
    v      = v % lim;
    if (sgn && (v >= lim / 2)) v = v - lim;
    return v[31:0];
  endfunction

  function automatic int model_free();
    for (int i = 0; i < NE; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < NE; i++) if (m_valid[i]) c++;
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NE; i++) begin
      m_valid[i] = 0; m_killed[i] = 0; m_id[i] = 0; m_off[i] = 0; m_size[i] = 0; m_sgn[i] = 0;
    end
    e_wbv = 0; e_wbid = 0; e_wbdata = '0;
  endtask

  // One clock cycle: drive at negedge, check handshake, then check registered results after the edge.
  task automatic step(input bit av, input int aid, input int aoff, input int asz, input bit asg,
                      input bit rv, input int ridx, input logic [31:0] rdata, input bit fl);
    int fi;
    bit rdy;
    bit hit;
    @(negedge clk);
    alloc_valid_i    = av;
    alloc_trans_id_i = 3'(aid);
    alloc_offset_i   = 2'(aoff);
    alloc_size_i     = 2'(asz);
    alloc_signed_i   = asg;
    resp_valid_i     = rv;
    resp_idx_i       = IB'(ridx);
    resp_data_i      = rdata;
    flush_i          = fl;
    #1;
    fi  = model_free();
    rdy = (fi >= 0) && !fl;
    chk("alloc_ready", 32'(alloc_ready_o), 32'(rdy));
    if (rdy) chk("alloc_idx", 32'(alloc_idx_o), 32'(fi));
    @(posedge clk);
    hit   = rv && (ridx < NE) && m_valid[ridx];
    e_wbv = hit && !m_killed[ridx] && !fl;
    if (e_wbv) begin
      e_wbid   = m_id[ridx];
      e_wbdata = ref_extract(rdata, m_off[ridx], m_size[ridx], m_sgn[ridx]);
    end
    if (hit) begin
      m_valid[ridx]  = 0;
      m_killed[ridx] = 0;
    end
    if (fl) for (int i = 0; i < NE; i++) if (m_valid[i]) m_killed[i] = 1;
    if (av && rdy) begin
      m_valid[fi] = 1; m_killed[fi] = 0; m_id[fi] = aid;
      m_off[fi] = aoff; m_size[fi] = asz; m_sgn[fi] = asg;
    end
    #1;
    chk("wb_valid", 32'(wb_valid_o), 32'(e_wbv));
    if (e_wbv) begin
      chk("wb_trans_id", 32'(wb_trans_id_o), 32'(e_wbid));
      chk("wb_data", wb_data_o, e_wbdata);
    end
    chk("count", 32'(count_o), 32'(model_count()));
    chk("empty", 32'(empty_o), 32'(model_count() == 0));
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, $urandom, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wb_valid"}, 32'(wb_valid_o), 32'd0);
    chk({tag, "_wb_id"}, 32'(wb_trans_id_o), 32'd0);
    chk({tag, "_wb_data"}, wb_data_o, 32'd0);
    chk({tag, "_empty"}, 32'(empty_o), 32'd1);
    chk({tag, "_count"}, 32'(count_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int fi;
    int sz;
    int off;
    bit fl;
    bit av;
    bit rv;
    int ridx;

    rst_i = 1; flush_i = 0; alloc_valid_i = 0; alloc_trans_id_i = '0; alloc_offset_i = '0;
    alloc_size_i = '0; alloc_signed_i = 0; resp_valid_i = 0; resp_idx_i = '0; resp_data_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    chk("reset_ready", 32'(alloc_ready_o), 32'd1);
    @(negedge clk);
    rst_i = 0;

    // Signed byte at offset 1.
    step(1, 5, 1, 0, 1, 0, 0, 32'h0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 32'h0000_8000, 0);
    chk("sb_wb_valid", 32'(wb_valid_o), 32'd1);
    chk("sb_wb_id", 32'(wb_trans_id_o), 32'd5);
    chk("sb_wb_data", wb_data_o, 32'hFFFF_FF80);

    // Fill both slots, then a freed slot is not reusable in the same cycle.
    step(1, 1, 0, 2, 0, 0, 0, 32'h0, 0);
    step(1, 2, 0, 2, 0, 0, 0, 32'h0, 0);
    chk("full_count", 32'(count_o), 32'd2);
    chk("full_ready", 32'(alloc_ready_o), 32'd0);
    step(1, 3, 0, 2, 0, 1, 1, 32'h1234_5678, 0);
    chk("same_cycle_count", 32'(count_o), 32'd1);
    step(1, 3, 0, 2, 0, 0, 0, 32'h0, 0);
    chk("reuse_count", 32'(count_o), 32'd2);

    // Flush with two outstanding: responses return silently.
    step(0, 0, 0, 0, 0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 0, 0, 1, 0, 32'hAAAA_AAAA, 0);
    chk("killed0_wb", 32'(wb_valid_o), 32'd0);
    chk("killed0_count", 32'(count_o), 32'd1);
    step(0, 0, 0, 0, 0, 1, 1, 32'h5555_5555, 0);
    chk("killed1_wb", 32'(wb_valid_o), 32'd0);
    chk("killed1_count", 32'(count_o), 32'd0);
    chk("killed1_empty", 32'(empty_o), 32'd1);

    // Flush coinciding with the response.
    step(1, 4, 0, 2, 0, 0, 0, 32'h0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 32'hCAFE_F00D, 1);
    chk("flush_resp_wb", 32'(wb_valid_o), 32'd0);
    chk("flush_resp_count", 32'(count_o), 32'd0);

    // Unsigned half at offset 2, then word.
    step(1, 6, 2, 1, 0, 0, 0, 32'h0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 32'hBEEF_1234, 0);
    chk("half_data", wb_data_o, 32'h0000_BEEF);
    step(1, 7, 0, 2, 0, 0, 0, 32'h0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 32'hBEEF_1234, 0);
    chk("word_data", wb_data_o, 32'hBEEF_1234);
    idle();

    // Randomized traffic on legal requests.
    for (int n = 0; n < 400; n++) begin
      fi   = model_free();
      fl   = ($urandom_range(0, 15) == 0);
      av   = ($urandom_range(0, 1) == 1) && (fi >= 0) && !fl;
      ridx = $urandom_range(0, NE - 1);
      rv   = m_valid[ridx] && ($urandom_range(0, 2) != 0);
      sz   = $urandom_range(0, 2);
      off  = (sz == 0) ? $urandom_range(0, 3) : (sz == 1) ? 2 * $urandom_range(0, 1) : 0;
      step(av, $urandom_range(0, 7), off, sz, $urandom_range(0, 1) == 1, rv, ridx, $urandom, fl);
    end
    for (int i = 0; i < NE; i++) if (m_valid[i]) step(0, 0, 0, 0, 0, 1, i, $urandom, 0);
    idle();

    // Asynchronous reset with loads outstanding and a write-back pending.
    step(1, 2, 0, 2, 0, 0, 0, 32'h0, 0);
    step(1, 3, 0, 2, 0, 0, 0, 32'h0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 32'h0BAD_BEEF, 0);
    chk("pre_rst_wb", 32'(wb_valid_o), 32'd1);
    #2;
    rst_i = 1;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    rst_i = 0;
    step(0, 0, 0, 0, 0, 1, 1, 32'hDEAD_BEEF, 0);
    chk("stale_wb", 32'(wb_valid_o), 32'd0);
    chk("stale_count", 32'(count_o), 32'd0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
